// File: rtl/traffic_pkg.sv
// Shared state encodings and helpers for the intersection controller.
package traffic_pkg;
   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_OFF     = 3'd0,
      ST_ALL_RED = 3'd1,
      ST_GO      = 3'd2,
      ST_SLOW    = 3'd3,
      ST_FLASH   = 3'd4
   } state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/traffic_phase_timer.sv
// Phase down-counter: loads DUR-1, counts to zero and holds there.
module traffic_phase_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_val,
   output logic             o_expire
);
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_val;
      else if (r_cnt != '0)
         r_cnt <= r_cnt - CNT_W'(1);
   end

   assign o_expire = (r_cnt == '0);
endmodule

// File: rtl/traffic_intersection_ctrl.sv
// N-approach round-robin intersection controller with ped
// extension and flashing-yellow maintenance mode.
module traffic_intersection_ctrl
   import traffic_pkg::*;
#(
   parameter int N_DIR       = 2,
   parameter int GREEN_CYC   = 8,
   parameter int PED_EXT_CYC = 4,
   parameter int YELLOW_CYC  = 3,
   parameter int ALLRED_CYC  = 2,
   parameter int FLASH_HALF  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       pow,
   input  logic                       str,
   input  logic                       flash_mode,
   input  logic [N_DIR-1:0]           ped_req,
   output logic [N_DIR-1:0]           g,
   output logic [N_DIR-1:0]           y,
   output logic [N_DIR-1:0]           r,
   output logic [N_DIR-1:0]           walk,
   output logic [ST_W-1:0]            curst,
   output logic [$clog2(N_DIR)-1:0]   active_dir
);
   localparam int DIR_W = $clog2(N_DIR);
   localparam int MAXD  = max2(max2(GREEN_CYC + PED_EXT_CYC, YELLOW_CYC),
                               max2(ALLRED_CYC, FLASH_HALF));
   localparam int CNT_W = $clog2(MAXD + 1);

   localparam logic [CNT_W-1:0] L_G  = CNT_W'(GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] L_GP = CNT_W'(GREEN_CYC + PED_EXT_CYC - 1);
   localparam logic [CNT_W-1:0] L_Y  = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] L_AR = CNT_W'(ALLRED_CYC - 1);
   localparam logic [CNT_W-1:0] L_FH = CNT_W'(FLASH_HALF - 1);
   localparam logic [DIR_W-1:0] LAST = DIR_W'(N_DIR - 1);

   state_t             r_state, w_nxt_state;
   logic [DIR_W-1:0]   r_dir, w_nxt_dir;
   logic [N_DIR-1:0]   r_ped, w_nxt_ped;
   logic               r_served, w_nxt_served;
   logic               r_flash_on, w_nxt_flash;
   logic [N_DIR-1:0]   r_g, r_y, r_r, r_walk;
   logic [N_DIR-1:0]   w_g, w_y, w_r, w_walk, w_onehot;
   logic               w_load, w_exp;
   logic [CNT_W-1:0]   w_load_val;

   traffic_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_val    (w_load_val),
      .o_expire (w_exp)
   );

   always_comb begin
      w_nxt_state  = r_state;
      w_nxt_dir    = r_dir;
      w_nxt_ped    = r_ped | ped_req;
      w_nxt_served = r_served;
      w_nxt_flash  = r_flash_on;
      w_load       = 1'b0;
      w_load_val   = '0;
      if (!pow) begin
         w_nxt_state  = ST_OFF;
         w_nxt_dir    = '0;
         w_nxt_ped    = '0;
         w_nxt_served = 1'b0;
         w_load       = 1'b1;
      end else begin
         unique case (r_state)
            ST_OFF: begin
               w_nxt_state = ST_ALL_RED;
               w_load      = 1'b1;
               w_load_val  = L_AR;
            end
            ST_ALL_RED: begin
               if (w_exp && flash_mode) begin
                  w_nxt_state = ST_FLASH;
                  w_nxt_flash = 1'b1;
                  w_load      = 1'b1;
                  w_load_val  = L_FH;
               end else if (w_exp && str) begin
                  // clear beats a same-edge request for this entry
                  w_nxt_state        = ST_GO;
                  w_nxt_served       = r_ped[r_dir];
                  w_nxt_ped[r_dir]   = 1'b0;
                  w_load             = 1'b1;
                  w_load_val         = r_ped[r_dir] ? L_GP : L_G;
               end
            end
            ST_GO: begin
               if (w_exp || flash_mode) begin
                  w_nxt_state = ST_SLOW;
                  w_load      = 1'b1;
                  w_load_val  = L_Y;
               end
            end
            ST_SLOW: begin
               if (w_exp) begin
                  w_nxt_state = ST_ALL_RED;
                  w_nxt_dir   = (r_dir == LAST) ? '0 : r_dir + DIR_W'(1);
                  w_load      = 1'b1;
                  w_load_val  = L_AR;
               end
            end
            ST_FLASH: begin
               if (!flash_mode) begin
                  w_nxt_state = ST_ALL_RED;
                  w_load      = 1'b1;
                  w_load_val  = L_AR;
               end else if (w_exp) begin
                  w_nxt_flash = ~r_flash_on;
                  w_load      = 1'b1;
                  w_load_val  = L_FH;
               end
            end
            default: begin
               w_nxt_state = ST_OFF;
               w_load      = 1'b1;
            end
         endcase
      end
   end

   // lamps decoded from next-state so they change with curst
   always_comb begin
      w_onehot = N_DIR'(1) << w_nxt_dir;
      w_g      = '0;
      w_y      = '0;
      w_r      = '0;
      w_walk   = '0;
      unique case (w_nxt_state)
         ST_ALL_RED: w_r = '1;
         ST_GO: begin
            w_g    = w_onehot;
            w_r    = ~w_onehot;
            w_walk = w_nxt_served ? w_onehot : '0;
         end
         ST_SLOW: begin
            w_y = w_onehot;
            w_r = ~w_onehot;
         end
         ST_FLASH: w_y = {N_DIR{w_nxt_flash}};
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_OFF;
         r_dir      <= '0;
         r_ped      <= '0;
         r_served   <= 1'b0;
         r_flash_on <= 1'b0;
         r_g        <= '0;
         r_y        <= '0;
         r_r        <= '0;
         r_walk     <= '0;
      end else begin
         r_state    <= w_nxt_state;
         r_dir      <= w_nxt_dir;
         r_ped      <= w_nxt_ped;
         r_served   <= w_nxt_served;
         r_flash_on <= w_nxt_flash;
         r_g        <= w_g;
         r_y        <= w_y;
         r_r        <= w_r;
         r_walk     <= w_walk;
      end
   end

   assign g          = r_g;
   assign y          = r_y;
   assign r          = r_r;
   assign walk       = r_walk;
   assign curst      = r_state;
   assign active_dir = r_dir;
endmodule
